e_mdu: RTL and testbench

//   Multi-cycle multiply/divide unit of the Execute stage, owning the HI/LO registers.
//   It consumes the mdu_* controls and D1/D2 operands from the ID/EX register (after forwarding).
//   It drives the HI/LO read value to the E-stage result mux, and a stall request to the hazard unit.

---
 rtl/e_mdu_if.sv | 35 +++
 rtl/e_mdu.sv | 136 +++++++++++++
 tb/tb_e_mdu.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// e_mdu_if: bundle of the E-stage multiply/divide unit signals.
//   master : the ID/EX side (drives controls/operands, reads busy/stall/rdata)
//   slave  : the MDU itself
// Signals:
//   req        exception/interrupt flush, suppresses issue this cycle
//   start      issue op
//   op[3:0]    0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU
//   we         MTHI/MTLO write strobe
//   r_sel      1 HI, 0 LO (read and write select)
//   a, b       forwarded rs / rt operands
//   busy       operation in progress (registered)
//   stall_req  busy | (start & ~req)
//   rdata      r_sel ? HI : LO
interface e_mdu_if;
  logic        req;
  logic        start;
  logic [3:0]  op;
  logic        we;
  logic        r_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] rdata;

  modport master (
    output req, start, op, we, r_sel, a, b,
    input  busy, stall_req, rdata
  );

  modport slave (
    input  req, start, op, we, r_sel, a, b,
    output busy, stall_req, rdata
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit of the Execute stage; owns HI/LO.
//   The full 64-bit result is computed at issue and parked in a pending
//   register; HI/LO take it when the busy countdown expires, so the visible
//   latency is MUL_CYCLES / DIV_CYCLES.
// Ports:
//   clk    core clock
//   reset  asynchronous, active-low reset
//   mdu    e_mdu_if.slave (controls, operands, busy, stall_req, rdata)
// Parameters:
//   MUL_CYCLES  busy cycles for MULT/MULTU/MADD*/MSUB* (>=1)
//   DIV_CYCLES  busy cycles for DIV/DIVU (>=1)
// Build option:
//   MDU_MADD_EN  when defined, ops 4-7 accumulate into {HI,LO};
//                when undefined, ops 4-7 are invalid and never issue.
module e_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  mdu
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q;
  logic           busy_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    hi_q, lo_q;
  logic [63:0]    pend_q;

  logic           sign_op, op_valid, op_is_div;
  logic [63:0]    prod_s, prod_u, result_d;
  logic [31:0]    abs_a, abs_b, den, quo, rem, div_lo, div_hi;
  logic [CW-1:0]  cnt_d;
`ifdef MDU_MADD_EN
  logic [63:0]    mac_prod;
`endif

  always_comb begin
    // Even opcodes are the signed flavours.
    sign_op   = ~mdu.op[0];
    op_is_div = (mdu.op[3:1] == 3'b001);
`ifdef MDU_MADD_EN
    op_valid  = ~mdu.op[3];
`else
    op_valid  = (mdu.op[3:2] == 2'b00);
`endif
    cnt_d     = op_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

    prod_s = {{32{mdu.a[31]}}, mdu.a} * {{32{mdu.b[31]}}, mdu.b};
    prod_u = {32'd0, mdu.a} * {32'd0, mdu.b};

    // One unsigned divider on magnitudes; signs are restored afterwards so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // The 8000_0000 / -1 overflow falls out naturally: quotient 8000_0000, rem 0.
    abs_a  = (sign_op && mdu.a[31]) ? (~mdu.a + 32'd1) : mdu.a;
    abs_b  = (sign_op && mdu.b[31]) ? (~mdu.b + 32'd1) : mdu.b;
    den    = (mdu.b == 32'd0) ? 32'd1 : abs_b;
    quo    = abs_a / den;
    rem    = abs_a % den;
    div_lo = (sign_op && (mdu.a[31] ^ mdu.b[31])) ? (~quo + 32'd1) : quo;
    div_hi = (sign_op && mdu.a[31]) ? (~rem + 32'd1) : rem;
    if (mdu.b == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = mdu.a;
    end

`ifdef MDU_MADD_EN
    mac_prod = mdu.op[0] ? prod_u : prod_s;
`endif
    case (mdu.op[2:0])
      3'd0:    result_d = prod_s;
      3'd1:    result_d = prod_u;
      3'd2,
      3'd3:    result_d = {div_hi, div_lo};
`ifdef MDU_MADD_EN
      // op[1] selects subtract (MSUB/MSUBU); accumulate from the current HI/LO.
      default: result_d = mdu.op[1] ? ({hi_q, lo_q} - mac_prod)
                                    : ({hi_q, lo_q} + mac_prod);
`else
      default: result_d = prod_s;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu.start) begin
            // start always shadows a same-cycle we, even if it cannot issue.
            if (!mdu.req && op_valid) begin
              pend_q  <= result_d;
              cnt_q   <= cnt_d;
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end
          end else if (mdu.we && !mdu.req) begin
            if (mdu.r_sel) hi_q <= mdu.a;
            else           lo_q <= mdu.a;
          end
        end
        BUSY: begin
          // start/we/req are deliberately ignored here: the op in flight
          // belongs to an older, committed instruction.
          if (cnt_q == CW'(1)) begin
            hi_q    <= pend_q[63:32];
            lo_q    <= pend_q[31:0];
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdu.busy      = busy_q;
  assign mdu.stall_req = busy_q | (mdu.start & ~mdu.req);
  assign mdu.rdata     = mdu.r_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu (MUL_CYCLES=5, DIV_CYCLES=10).
//   A behavioural model (plain integer arithmetic and a remaining-cycles
//   count) is checked against busy/stall_req/rdata on every falling edge;
//   directed scenarios add hand-computed literal expectations, then a
//   randomized phase exercises the same model.
module tb_e_mdu;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  e_mdu_if bus ();

  e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_left = 0;

  function automatic bit m_valid(logic [3:0] op);
`ifdef MDU_MADD_EN
    return op < 4'd8;
`else
    return op < 4'd4;
`endif
  endfunction

  function automatic logic [63:0] m_compute(logic [3:0] op, logic [31:0] a,
                                            logic [31:0] b, logic [63:0] hilo);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sp = longint'(int'(a)) * longint'(int'(b));
    up = 64'(a) * 64'(b);
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0: return sp;
      4'd1: return up;
      4'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd4: return hilo + sp;
      4'd5: return hilo + up;
      4'd6: return hilo - sp;
      default: return hilo - up;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (bus.start) begin
      if (!bus.req && m_valid(bus.op)) begin
        m_pend = m_compute(bus.op, bus.a, bus.b, {m_hi, m_lo});
        m_left = (bus.op == 4'd2 || bus.op == 4'd3) ? 10 : 5;
      end
    end else if (bus.we && !bus.req) begin
      if (bus.r_sel) m_hi = bus.a;
      else           m_lo = bus.a;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy",      {31'd0, bus.busy},      {31'd0, m_left > 0});
    chk("stall_req", {31'd0, bus.stall_req}, {31'd0, (m_left > 0) | (bus.start & ~bus.req)});
    chk("rdata",     bus.rdata,              bus.r_sel ? m_hi : m_lo);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic [3:0] o, logic w, logic rs, logic rq,
                       logic [31:0] aa, logic [31:0] bb);
    bus.start = s; bus.op = o; bus.we = w; bus.r_sel = rs; bus.req = rq;
    bus.a = aa; bus.b = bb;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'd0, 1'b0, bus.r_sel, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic issue(logic [3:0] o, logic [31:0] aa, logic [31:0] bb);
    step();
    drive(1'b1, o, 1'b0, 1'b0, 1'b0, aa, bb);
    step();
    idle_inputs();
  endtask

  // Counts busy cycles until busy falls; bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
      cycles++;
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic read(logic sel, logic [31:0] exp, string name);
    #1 bus.r_sel = sel;
    #1 chk(name, bus.rdata, exp);
  endtask

  int cyc;

  initial begin
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    #1 chk("reset_lo", bus.rdata, 32'd0);
    bus.r_sel = 1'b1;
    #1 chk("reset_hi", bus.rdata, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1. MULT -3 * 7
    issue(4'd0, 32'hFFFF_FFFD, 32'd7);
    wait_idle(cyc);
    chk("mult_busy_len", cyc, 32'd5);
    read(1'b1, 32'hFFFF_FFFF, "mult_hi");
    read(1'b0, 32'hFFFF_FFEB, "mult_lo");

    // 2. DIVU 100 / 7, DIV -7 / 2
    issue(4'd3, 32'd100, 32'd7);
    wait_idle(cyc);
    chk("divu_busy_len", cyc, 32'd10);
    read(1'b0, 32'd14, "divu_lo");
    read(1'b1, 32'd2,  "divu_hi");
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    read(1'b0, 32'hFFFF_FFFD, "div_neg_lo");
    read(1'b1, 32'hFFFF_FFFF, "div_neg_hi");

    // 3. divide by zero, signed overflow
    issue(4'd2, 32'd5, 32'd0);
    wait_idle(cyc);
    read(1'b0, 32'hFFFF_FFFF, "div0_lo");
    read(1'b1, 32'd5,         "div0_hi");
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    read(1'b0, 32'h8000_0000, "divov_lo");
    read(1'b1, 32'd0,         "divov_hi");

    // 4. start+we while busy are ignored
    issue(4'd0, 32'd6, 32'd7);
    drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
    step();
    idle_inputs();
    wait_idle(cyc);
    read(1'b1, 32'd0,  "busy_ign_hi");
    read(1'b0, 32'd42, "busy_ign_lo");

    // 5. req blocks start and we; we alone writes
    step();
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd3);
    step();
    idle_inputs();
    #2 chk("req_blocks_start", {31'd0, bus.busy}, 32'd0);
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 32'd9, 32'd0);
    step();
    idle_inputs();
    read(1'b1, 32'd0, "req_blocks_we");
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
    step();
    idle_inputs();
    read(1'b0, 32'd9, "we_lo");

    // 6. reset mid-DIV, then MADDU
    issue(4'd2, 32'd100, 32'd7);
    step(); step();
    reset = 1'b0;
    #1 chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    read(1'b0, 32'd0, "rst_lo");
    read(1'b1, 32'd0, "rst_hi");
    step();
    reset = 1'b1;
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
    step();
    idle_inputs();
    issue(4'd5, 32'd3, 32'd4);
    wait_idle(cyc);
`ifdef MDU_MADD_EN
    read(1'b0, 32'd22, "maddu_lo");
`else
    read(1'b0, 32'd10, "maddu_lo");
`endif
    read(1'b1, 32'd0, "maddu_hi");

    // Randomized phase, checked by the per-cycle compare process.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] aa, bb;
      logic [3:0]  o;
      int          sel;
      step();
      sel = $urandom_range(0, 9);
      aa  = $urandom;
      bb  = $urandom;
      if (sel == 0) bb = 32'd0;
      else if (sel == 1) begin aa = 32'h8000_0000; bb = 32'hFFFF_FFFF; end
      else if (sel < 5) begin
        aa = $urandom_range(0, 50);
        bb = $urandom_range(1, 9);
        if ($urandom_range(0, 1) == 1) aa = -aa;
        if ($urandom_range(0, 1) == 1) bb = -bb;
      end
      o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      drive($urandom_range(0, 2) == 0, o, $urandom_range(0, 4) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, aa, bb);
    end
    step();
    idle_inputs();
    wait_idle(cyc);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
